// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants for the FIFO read-side byte packer: state encoding,
// default geometry and helpers that size the lane counter and idle timer.
package fifo_rd_packer_pkg;

    localparam logic FILL = 1'b0;
    localparam logic SEND = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;
    localparam int DEF_TIMEOUT    = 16;

    // The lane counter must be able to hold PACK itself, hence the extra bit.
    function automatic int cnt_width(input int pack);
        return $clog2(pack) + 1;
    endfunction

    // Wide enough to hold TIMEOUT-1, the timer load value.
    function automatic int idle_width(input int timeout);
        return $clog2(timeout);
    endfunction

    localparam int CNT_W  = cnt_width(DEF_PACK);
    localparam int IDLE_W = idle_width(DEF_TIMEOUT);

endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle timer for the packer. Down-counter loaded with TIMEOUT-1; each
// enabled cycle counts down, and expire is raised on the enabled cycle that
// finds the counter at zero, i.e. the TIMEOUT-th consecutive idle cycle.
module pack_idle_timer
    import fifo_rd_packer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int IW = idle_width(TIMEOUT);
    localparam logic [IW-1:0] LOAD = IW'(TIMEOUT - 1);

    logic [IW-1:0] remain;

    // Reload on clear, otherwise count down while idle and not yet at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= LOAD;
        end else if (clear) begin
            remain <= LOAD;
        end else if (enable && (remain != '0)) begin
            remain <= remain - IW'(1);
        end
    end

    assign expire = enable && (remain == '0);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side drain stage for the dual-clock FIFO. Pops one byte per cycle
// while the FIFO is non-empty, packs PACK bytes (first popped in the low
// lane) into one word, and offers it on a valid/ready port. A partial word
// leaves early on flush or after TIMEOUT idle cycles, with out_keep marking
// the populated lanes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | issuing reads and capturing bytes into lanes
//   SEND  | word presented on out_valid; no reads, flush ignored
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_dout,
    output logic                         fifo_r_en,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [PACK-1:0]              out_keep
);

    localparam int CW     = cnt_width(PACK);
    localparam int LANE_W = CW - 1;
    localparam logic [CW:0]   PACK_SUM  = (CW + 1)'(PACK);
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

    logic          state;
    logic          state_next;
    logic [CW-1:0] cnt;
    logic          rd_pend;
    logic [CW:0]   cnt_sum;
    logic          capture;
    logic          flush_take;
    logic          idle_cond;
    logic          idle_clear;
    logic          idle_expire;

    // A byte returns the cycle after its read, so lanes already claimed by an
    // in-flight read count against the word when deciding to issue another.
    assign cnt_sum    = {1'b0, cnt} + {{CW{1'b0}}, rd_pend};
    assign capture    = (state == FILL) && rd_pend;
    // Flush is only honoured with no byte in flight, so the emitted word
    // never loses a popped byte; the requester holds flush until it lands.
    assign flush_take = (state == FILL) && flush && (cnt != '0) && !rd_pend;
    assign idle_cond  = (state == FILL) && (cnt != '0) && !rd_pend && !fifo_r_en;
    assign idle_clear = capture || (state_next == SEND);

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (idle_clear),
        .enable (idle_cond),
        .expire (idle_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave FILL when the last lane is captured, on an accepted
    // flush or on idle expiry; leave SEND when the word is taken.
    always_comb begin
        state_next = state;
        if (state == FILL) begin
            if ((capture && (cnt == LAST_LANE)) || flush_take || idle_expire) begin
                state_next = SEND;
            end
        end else begin
            if (out_ready) begin
                state_next = FILL;
            end
        end
    end

    // Outputs: valid in SEND, reads only in FILL with room and data available.
    always_comb begin
        fifo_r_en = 1'b0;
        out_valid = 1'b0;
        if (state == SEND) begin
            out_valid = 1'b1;
        end else if (!rst && !fifo_empty && !flush_take && (cnt_sum < PACK_SUM)) begin
            fifo_r_en = 1'b1;
        end
    end

    // Datapath: track the in-flight read, drop returning bytes into the next
    // lane, and clear the word once it has been handed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            cnt      <= '0;
            out_data <= '0;
            out_keep <= '0;
        end else begin
            rd_pend <= fifo_r_en;
            if (state == SEND) begin
                if (out_ready) begin
                    cnt      <= '0;
                    out_data <= '0;
                    out_keep <= '0;
                end
            end else if (capture) begin
                cnt <= cnt + CW'(1);
                for (int i = 0; i < PACK; i++) begin
                    if (cnt[LANE_W-1:0] == LANE_W'(i)) begin
                        out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
                        out_keep[i]                          <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer with DATA_WIDTH=8, PACK=4, TIMEOUT=16. A simple
// FIFO model returns data one clock after a sampled read; inputs change on
// the falling edge and outputs are sampled there too.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_r_en;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW*PK-1:0] out_data;
    logic [PK-1:0] out_keep;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep)
    );

    always #5 clk = ~clk;

    // FIFO model: pushes from the stimulus, pops on a sampled read enable.
    logic [7:0] mem [0:127];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    int underflows = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_r_en) begin
            pops <= pops + 1;
            if (rd_ptr == wr_ptr) begin
                underflows <= underflows + 1;
            end else begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic wait_valid(input int limit, output int k, output bit got);
        k   = 0;
        got = 1'b0;
        while (k < limit && !got) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got = out_valid;
        end
    endtask

    typedef enum int {M_FULL, M_TIMEOUT, M_FLUSH} mode_t;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        mode_t       mode;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        int bad;
        int nw;
        bit got;
        logic [31:0] words [2];
        int tv [2];

        // Latency counts rising edges from the push until out_valid is seen:
        // full = PACK+1, flush = n+2, timeout = n+1+TIMEOUT.
        vecs[0] = '{4, 32'h04030201, M_FULL,    32'h04030201, 4'b1111, 5};
        vecs[1] = '{2, 32'h00002211, M_TIMEOUT, 32'h00002211, 4'b0011, 19};
        vecs[2] = '{3, 32'h000C0B0A, M_FLUSH,   32'h000C0B0A, 4'b0111, 5};
        vecs[3] = '{1, 32'h000000A5, M_FLUSH,   32'h000000A5, 4'b0001, 3};
        vecs[4] = '{4, 32'hEFBEADDE, M_FULL,    32'hEFBEADDE, 4'b1111, 5};
        vecs[5] = '{3, 32'h00FF8001, M_TIMEOUT, 32'h00FF8001, 4'b0111, 20};
        vecs[6] = '{1, 32'h0000005A, M_TIMEOUT, 32'h0000005A, 4'b0001, 18};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_keep",  out_keep, 0);
        check("reset_out_data",  out_data, 0);
        check("reset_r_en",      fifo_r_en, 0);
        rst = 1'b0;

        // Flush with nothing captured must not produce a word or a pop.
        p0  = pops;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            flush = (i < 8);
            @(negedge clk);
            if (out_valid) bad++;
        end
        flush = 1'b0;
        check("flush_cnt0_valid_cycles", bad, 0);
        check("flush_cnt0_pops", pops - p0, 0);

        // Table of single-word cases: full, timeout and flush endings.
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < vecs[v].n; j++) push(vecs[v].bytes[j*8 +: 8]);
            k   = 0;
            got = 1'b0;
            while (k < 60 && !got) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                if (out_valid) got = 1'b1;
                else flush = (vecs[v].mode == M_FLUSH) && (k == vecs[v].n + 1);
            end
            flush = 1'b0;
            check($sformatf("vec%0d_valid_seen", v), got, 1);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
            check($sformatf("vec%0d_keep", v), out_keep, vecs[v].exp_keep);
            check($sformatf("vec%0d_latency", v), k, vecs[v].exp_lat);
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", v), out_valid, 0);
            check($sformatf("vec%0d_keep_clear", v), out_keep, 0);
        end

        // Backpressure: word held stable, no pops while the FIFO has data.
        out_ready = 1'b0;
        p0 = pops;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        push(8'h99); push(8'hAA); push(8'hBB); push(8'hCC);
        wait_valid(20, k, got);
        check("bp_latency", k, 5);
        check("bp_data", out_data, 32'h88776655);
        check("bp_keep", out_keep, 4'b1111);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== 32'h88776655 || out_keep !== 4'b1111 || fifo_r_en)
                bad++;
        end
        check("bp_stable_cycles", bad, 0);
        check("bp_pops", pops - p0, 4);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid_drop", out_valid, 0);
        wait_valid(20, k, got);
        check("bp_second_latency", k, 5);
        check("bp_second_data", out_data, 32'hCCBBAA99);
        @(negedge clk);

        // Streaming eight bytes: two words PACK+2 cycles apart.
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(8'(i));
        k  = 0;
        nw = 0;
        while (k < 40 && nw < 2) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) begin
                words[nw] = out_data;
                tv[nw]    = k;
                nw++;
            end
        end
        check("stream_words", nw, 2);
        check("stream_word0", words[0], 32'h04030201);
        check("stream_word1", words[1], 32'h08070605);
        check("stream_first_latency", tv[0], 5);
        check("stream_period", tv[1] - tv[0], PK + 2);
        check("stream_pops", pops - p0, 8);
        @(negedge clk);
        check("stream_idle_after", out_valid, 0);

        // Reset mid-word with a byte in flight, then refill from reset.
        p0 = pops;
        push(8'h31); push(8'h32); push(8'h33);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_keep_before", out_keep, 4'b0011);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_keep", out_keep, 0);
        check("midrst_out_data", out_data, 0);
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        #1;
        check("midrst_r_en_forced", fifo_r_en, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (fifo_r_en) bad++;
        end
        check("midrst_r_en_cycles", bad, 0);
        rst = 1'b0;
        wait_valid(20, k, got);
        check("midrst_refill_latency", k, 5);
        check("midrst_refill_data", out_data, 32'h24232221);
        check("midrst_refill_keep", out_keep, 4'b1111);
        @(negedge clk);
        check("midrst_pops", pops - p0, 7);

        check("no_underflow", underflows, 0);
        check("fifo_drained", wr_ptr - rd_ptr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
